// File: rtl/riscv_defines.sv
// Shared core definitions: the store buffer entry layout and its default depth.
package riscv_defines;

   localparam int SB_DEPTH = 4;

   typedef struct packed {
      logic [29:0] waddr;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
   } sb_entry_t;

endpackage

// File: rtl/store_buffer.sv
// Posted-write buffer between store alignment and the data-memory port.
// Drains stores in order over req/gnt and flags loads that hit a buffered word.
module store_buffer
   import riscv_defines::*;
#(
   parameter int DEPTH = SB_DEPTH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       st_valid,
   input  logic [31:0]                st_addr,
   input  logic [3:0]                 st_wstrb,
   input  logic [31:0]                st_wdata,
   output logic                       st_ready,
   input  logic                       ld_valid,
   input  logic [31:0]                ld_addr,
   output logic                       ld_hazard,
   output logic                       mem_req,
   output logic [31:0]                mem_addr,
   output logic [3:0]                 mem_wstrb,
   output logic [31:0]                mem_wdata,
   input  logic                       mem_gnt,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("store_buffer: DEPTH must be a power of 2 and at least 2");
   end

   sb_entry_t         entries [DEPTH];
   logic [DEPTH-1:0]  vld;
   logic [PW-1:0]     head;
   logic [PW-1:0]     tail;
   logic [CW-1:0]     cnt;
   logic              enq;
   logic              deq;
   logic [DEPTH-1:0]  hit;
   sb_entry_t         head_e;
   logic              unused_low_bits;

   assign unused_low_bits = ^{st_addr[1:0], ld_addr[1:0]};

   // Readiness depends on state only; a same-cycle grant never makes room.
   assign st_ready = (cnt != CW'(DEPTH));
   assign mem_req  = (cnt != '0);
   assign empty    = (cnt == '0);
   assign count    = cnt;

   assign enq = st_valid && st_ready && (st_wstrb != 4'b0000);
   assign deq = mem_req && mem_gnt;

   assign head_e    = entries[head];
   assign mem_addr  = mem_req ? {head_e.waddr, 2'b00} : 32'h0;
   assign mem_wstrb = mem_req ? head_e.wstrb : 4'h0;
   assign mem_wdata = mem_req ? head_e.wdata : 32'h0;

   for (genvar i = 0; i < DEPTH; i++) begin : g_hazard
      assign hit[i] = vld[i] && (entries[i].waddr == ld_addr[31:2]);
   end

   assign ld_hazard = ld_valid && (|hit);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head <= '0;
         tail <= '0;
         cnt  <= '0;
         vld  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            entries[i] <= '0;
         end
      end else begin
         // enq and deq never target the same slot: that needs count 0 or full.
         if (enq) begin
            entries[tail] <= '{waddr: st_addr[31:2], wstrb: st_wstrb, wdata: st_wdata};
            vld[tail]     <= 1'b1;
            tail          <= tail + 1'b1;
         end
         if (deq) begin
            vld[head] <= 1'b0;
            head      <= head + 1'b1;
         end
         case ({enq, deq})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus a randomized
// run compared against a queue-based model of the buffer.
module tb_store_buffer;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        st_valid;
   logic [31:0] st_addr;
   logic [3:0]  st_wstrb;
   logic [31:0] st_wdata;
   logic        st_ready;
   logic        ld_valid;
   logic [31:0] ld_addr;
   logic        ld_hazard;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_wdata;
   logic        mem_gnt;
   logic        empty;
   logic [2:0]  count;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [29:0] waddr;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
   } store_t;

   store_t model_q [$];

   always #5 clk = ~clk;

   store_buffer #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .st_valid  (st_valid),
      .st_addr   (st_addr),
      .st_wstrb  (st_wstrb),
      .st_wdata  (st_wdata),
      .st_ready  (st_ready),
      .ld_valid  (ld_valid),
      .ld_addr   (ld_addr),
      .ld_hazard (ld_hazard),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_wstrb (mem_wstrb),
      .mem_wdata (mem_wdata),
      .mem_gnt   (mem_gnt),
      .empty     (empty),
      .count     (count)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic sv, input logic [31:0] sa, input logic [3:0] ss,
                        input logic [31:0] sd, input logic lv, input logic [31:0] la,
                        input logic g);
      st_valid = sv;
      st_addr  = sa;
      st_wstrb = ss;
      st_wdata = sd;
      ld_valid = lv;
      ld_addr  = la;
      mem_gnt  = g;
   endtask

   task automatic idle(input logic g);
      drive(1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, g);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h0, 1'b0);
      tick();
      tick();
      n_checks++;
      if ({mem_req, empty, st_ready, ld_hazard, count} !== {1'b0, 1'b1, 1'b1, 1'b0, 3'd0}) begin
         n_fail++;
         $display("FAIL reset_flags got req=%b empty=%b ready=%b haz=%b count=%0d want 0 1 1 0 0",
                  mem_req, empty, st_ready, ld_hazard, count);
      end
      n_checks++;
      if ({mem_addr, mem_wstrb, mem_wdata} !== 68'h0) begin
         n_fail++;
         $display("FAIL reset_mem_bus got addr=%h wstrb=%h data=%h want all zero",
                  mem_addr, mem_wstrb, mem_wdata);
      end
      rst = 1'b0;
      idle(1'b0);
      tick();
   endtask

   task automatic test_single();
      drive(1'b1, 32'h1000_0006, 4'b1100, 32'hBEEF_0000, 1'b0, 32'h0, 1'b0);
      n_checks++;
      if (mem_req !== 1'b0) begin
         n_fail++;
         $display("FAIL single_no_bypass got mem_req=%b want 0", mem_req);
      end
      tick();
      idle(1'b0);
      for (int i = 0; i < 3; i++) begin
         #1;
         n_checks++;
         if ({mem_req, mem_addr, mem_wstrb, mem_wdata, count, empty} !==
             {1'b1, 32'h1000_0004, 4'b1100, 32'hBEEF_0000, 3'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL single_head[%0d] got req=%b addr=%h wstrb=%b data=%h count=%0d empty=%b want 1 10000004 1100 beef0000 1 0",
                     i, mem_req, mem_addr, mem_wstrb, mem_wdata, count, empty);
         end
         tick();
      end
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      #1;
      n_checks++;
      if ({mem_req, empty} !== 2'b01) begin
         n_fail++;
         $display("FAIL single_drained got req=%b empty=%b want 0 1", mem_req, empty);
      end
   endtask

   task automatic test_fill_order();
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 32'h100 + 32'(4 * i), 4'hF, 32'hA000_0000 + 32'(i), 1'b0, 32'h0, 1'b0);
         #1;
         n_checks++;
         if (st_ready !== (i < 4)) begin
            n_fail++;
            $display("FAIL fill_ready[%0d] got %b want %b", i, st_ready, (i < 4));
         end
         tick();
      end
      idle(1'b0);
      #1;
      n_checks++;
      if ({count, st_ready} !== {3'd4, 1'b0}) begin
         n_fail++;
         $display("FAIL fill_full got count=%0d ready=%b want 4 0", count, st_ready);
      end
      mem_gnt = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_checks++;
         if ({mem_req, mem_addr, mem_wdata} !== {1'b1, 32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i)}) begin
            n_fail++;
            $display("FAIL fill_drain[%0d] got req=%b addr=%h data=%h want 1 %h %h",
                     i, mem_req, mem_addr, mem_wdata, 32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i));
         end
         tick();
      end
      mem_gnt = 1'b0;
      #1;
      n_checks++;
      if (empty !== 1'b1) begin
         n_fail++;
         $display("FAIL fill_fifth_dropped got empty=%b want 1", empty);
      end
   endtask

   task automatic test_full_grant();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'h400 + 32'(4 * i), 4'h3, 32'(i), 1'b0, 32'h0, 1'b0);
         tick();
      end
      drive(1'b1, 32'h500, 4'hF, 32'h5555_5555, 1'b0, 32'h0, 1'b1);
      #1;
      n_checks++;
      if (st_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL fullgnt_ready_same_cycle got %b want 0", st_ready);
      end
      tick();
      idle(1'b0);
      #1;
      n_checks++;
      if ({count, st_ready} !== {3'd3, 1'b1}) begin
         n_fail++;
         $display("FAIL fullgnt_after got count=%0d ready=%b want 3 1", count, st_ready);
      end
      mem_gnt = 1'b1;
      for (int i = 1; i < 4; i++) begin
         n_checks++;
         if (mem_addr !== 32'h400 + 32'(4 * i)) begin
            n_fail++;
            $display("FAIL fullgnt_drain[%0d] got addr=%h want %h", i, mem_addr, 32'h400 + 32'(4 * i));
         end
         tick();
         #1;
      end
      mem_gnt = 1'b0;
      n_checks++;
      if (empty !== 1'b1) begin
         n_fail++;
         $display("FAIL fullgnt_store_leaked got empty=%b want 1", empty);
      end
   endtask

   task automatic test_simul_enq_deq();
      drive(1'b1, 32'h600, 4'hF, 32'h600, 1'b0, 32'h0, 1'b0);
      tick();
      for (int k = 1; k <= 4; k++) begin
         drive(1'b1, 32'h600 + 32'(4 * k), 4'hF, 32'h600 + 32'(k), 1'b0, 32'h0, 1'b1);
         #1;
         n_checks++;
         if ({mem_req, count, mem_addr} !== {1'b1, 3'd1, 32'h600 + 32'(4 * (k - 1))}) begin
            n_fail++;
            $display("FAIL simul[%0d] got req=%b count=%0d addr=%h want 1 1 %h",
                     k, mem_req, count, mem_addr, 32'h600 + 32'(4 * (k - 1)));
         end
         tick();
      end
      idle(1'b1);
      #1;
      n_checks++;
      if (mem_addr !== 32'h610) begin
         n_fail++;
         $display("FAIL simul_last got addr=%h want 00000610", mem_addr);
      end
      tick();
      mem_gnt = 1'b0;
      #1;
      n_checks++;
      if (empty !== 1'b1) begin
         n_fail++;
         $display("FAIL simul_empty got empty=%b want 1", empty);
      end
   endtask

   task automatic test_hazard();
      drive(1'b1, 32'h2000, 4'b0001, 32'h0000_00AA, 1'b0, 32'h0, 1'b0);
      tick();
      drive(1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h2003, 1'b0);
      #1;
      n_checks++;
      if (ld_hazard !== 1'b1) begin
         n_fail++;
         $display("FAIL hazard_hit got %b want 1", ld_hazard);
      end
      ld_addr = 32'h2004;
      #1;
      n_checks++;
      if (ld_hazard !== 1'b0) begin
         n_fail++;
         $display("FAIL hazard_next_word got %b want 0", ld_hazard);
      end
      ld_addr  = 32'h2003;
      ld_valid = 1'b0;
      #1;
      n_checks++;
      if (ld_hazard !== 1'b0) begin
         n_fail++;
         $display("FAIL hazard_no_load got %b want 0", ld_hazard);
      end
      ld_valid = 1'b1;
      mem_gnt  = 1'b1;
      #1;
      n_checks++;
      if (ld_hazard !== 1'b1) begin
         n_fail++;
         $display("FAIL hazard_grant_cycle got %b want 1", ld_hazard);
      end
      tick();
      mem_gnt = 1'b0;
      #1;
      n_checks++;
      if (ld_hazard !== 1'b0) begin
         n_fail++;
         $display("FAIL hazard_after_grant got %b want 0", ld_hazard);
      end
      idle(1'b0);
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h700 + 32'(4 * i), 4'hF, 32'(i), 1'b0, 32'h0, 1'b0);
         tick();
      end
      idle(1'b1);
      #1;
      n_checks++;
      if ({count, mem_req} !== {3'd3, 1'b1}) begin
         n_fail++;
         $display("FAIL arst_pre got count=%0d req=%b want 3 1", count, mem_req);
      end
      #1;
      rst = 1'b1;
      #1;
      n_checks++;
      if ({mem_req, empty, count} !== {1'b0, 1'b1, 3'd0}) begin
         n_fail++;
         $display("FAIL arst_async got req=%b empty=%b count=%0d want 0 1 0", mem_req, empty, count);
      end
      tick();
      rst = 1'b0;
      idle(1'b0);
      tick();
      tick();
      n_checks++;
      if (mem_req !== 1'b0) begin
         n_fail++;
         $display("FAIL arst_after_release got req=%b want 0", mem_req);
      end
      drive(1'b1, 32'h800, 4'h0, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0);
      tick();
      idle(1'b0);
      #1;
      n_checks++;
      if ({count, empty} !== {3'd0, 1'b1}) begin
         n_fail++;
         $display("FAIL arst_zero_strobe got count=%0d empty=%b want 0 1", count, empty);
      end
   endtask

   task automatic test_random();
      logic        sv, lv, g, exp_haz;
      logic [3:0]  ss;
      logic [31:0] sa, sd, la;
      int          sz;
      store_t      s;
      model_q.delete();
      for (int c = 0; c < 400; c++) begin
         sv = ($urandom_range(0, 3) != 0);
         ss = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
         sa = 32'h3000 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
         sd = $urandom;
         lv = 1'($urandom_range(0, 1));
         la = 32'h3000 + 32'(4 * $urandom_range(0, 9)) + 32'($urandom_range(0, 3));
         g  = ($urandom_range(0, 2) == 0);
         drive(sv, sa, ss, sd, lv, la, g);
         #1;
         sz = model_q.size();
         exp_haz = 1'b0;
         foreach (model_q[i]) begin
            if (model_q[i].waddr == la[31:2]) exp_haz = lv;
         end
         n_checks++;
         if ({mem_req, st_ready, empty, count, ld_hazard} !==
             {sz != 0, sz != DEPTH, sz == 0, 3'(sz), exp_haz}) begin
            n_fail++;
            $display("FAIL rand_flags[%0d] got req=%b ready=%b empty=%b count=%0d haz=%b want size=%0d haz=%b",
                     c, mem_req, st_ready, empty, count, ld_hazard, sz, exp_haz);
         end
         if (sz != 0) begin
            n_checks++;
            if ({mem_addr, mem_wstrb, mem_wdata} !== {model_q[0].waddr, 2'b00, model_q[0].wstrb, model_q[0].wdata}) begin
               n_fail++;
               $display("FAIL rand_head[%0d] got addr=%h wstrb=%h data=%h want %h %h %h",
                        c, mem_addr, mem_wstrb, mem_wdata, {model_q[0].waddr, 2'b00},
                        model_q[0].wstrb, model_q[0].wdata);
            end
         end
         tick();
         if (g && sz > 0) void'(model_q.pop_front());
         if (sv && ss != 4'h0 && sz < DEPTH) begin
            s.waddr = sa[31:2];
            s.wstrb = ss;
            s.wdata = sd;
            model_q.push_back(s);
         end
      end
      idle(1'b1);
      for (int i = 0; i < 10 && !empty; i++) tick();
      idle(1'b0);
      n_checks++;
      if (empty !== 1'b1) begin
         n_fail++;
         $display("FAIL rand_final_drain got empty=%b count=%0d want 1 0", empty, count);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill_order();
      test_full_grant();
      test_simul_enq_deq();
      test_hazard();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
